bingo_turn_sched: RTL and testbench

//  Slave-side turn scheduler for the bingo game. Sequences handle_guess_slave: clears the card, alternates P1 (remote) / P2 (local) turns,

---
 rtl/bingo_turn_sched_pkg.sv | 44 ++++
 rtl/bingo_line_counter.sv | 20 ++
 rtl/bingo_turn_sched.sv | 195 +++++++++++++++++++
 tb/tb_bingo_turn_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bingo_turn_sched_pkg.sv
// Shared types and constants for the bingo slave turn scheduler.
// Game-state codes and interboard message types live here so the scheduler,
// the line counter and anything talking to the interboard link agree on them.
package bingo_turn_sched_pkg;

    // Values reported on cur_game_state
    localparam logic [3:0] GAME_IDLE          = 4'd0;
    localparam logic [3:0] GAME_WAIT_P1_GUESS = 4'd1;
    localparam logic [3:0] GAME_P2_GUESS      = 4'd2;
    localparam logic [3:0] GAME_OVER          = 4'd3;

    // Interboard message types
    localparam logic [2:0] MSG_SEL_NUM   = 3'd1;
    localparam logic [2:0] MSG_STATE_WIN = 3'd2;

    // 5 rows + 5 cols + 2 diagonals
    localparam int unsigned NUM_LINES = 12;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StIssue,
        StWait,
        StCheck,
        StOver
    } sched_state_e;

    // Bit mask of line idx on the 5x5 card (bit = row*5+col).
    // 0..4 rows, 5..9 cols, 10 main diagonal, 11 anti-diagonal.
    function automatic logic [24:0] line_mask(input int unsigned idx);
        logic [24:0] mask;
        if (idx < 5) begin
            mask = 25'h000001F << (5 * idx);
        end else if (idx < 10) begin
            mask = 25'h0108421 << (idx - 5);
        end else if (idx == 10) begin
            mask = 25'h1041041;
        end else begin
            mask = 25'h0111110;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bingo_line_counter.sv
// Combinational count of completed lines on a 5x5 marked map.
// A line counts only when all five of its cells are marked; result 0..12.
module bingo_line_counter
    import bingo_turn_sched_pkg::*;
(
    input  logic [24:0] circle,
    output logic [3:0]  count
);

    // Sum one per fully marked line
    always_comb begin
        count = 4'd0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            if ((circle & line_mask(i)) == line_mask(i)) begin
                count = count + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bingo_turn_sched.sv
// Slave-side turn scheduler for the bingo game.
// Clears the card, alternates remote (P1) and local (P2) turns, arms the guess
// handler, counts completed lines after each guess and declares the result.
// Optional feature: define BINGO_LINK_TIMEOUT_EN to end the game when the
// remote side stays silent for TIMEOUT_CYCLES during its turn.
module bingo_turn_sched
    import bingo_turn_sched_pkg::*;
#(
    parameter int unsigned LINE_TARGET    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        interboard_rst,
    input  logic        game_start,
    input  logic        first_player,
    input  logic        interboard_en,
    input  logic [2:0]  interboard_msg_type,
    input  logic        guess_done,
    input  logic [24:0] circle,
    output logic        clear_guess,
    output logic        start_guess,
    output logic [3:0]  cur_game_state,
    output logic        send_en,
    output logic [2:0]  send_msg_type,
    output logic [3:0]  line_count,
    output logic        game_over,
    output logic        winner,
    output logic        link_timeout
);

    sched_state_e state_q, state_d;

    logic       soft_rst;
    logic       turn_q;        // 0 = remote (P1), 1 = local (P2)
    logic [3:0] line_count_q;
    logic [3:0] cur_state_q;
    logic       winner_q;
    logic [3:0] count;
    logic       target_hit;
    logic       remote_win;
    logic       timeout_fire;

    // Peer abort behaves exactly like a local reset
    assign soft_rst = ~rst_n | interboard_rst;

    bingo_line_counter u_line_counter (
        .circle (circle),
        .count  (count)
    );

    assign target_hit = 32'(count) >= LINE_TARGET;
    assign remote_win = (state_q == StWait) && !turn_q && interboard_en &&
                        (interboard_msg_type == MSG_STATE_WIN);

`ifdef BINGO_LINK_TIMEOUT_EN
    logic [19:0] tmo_cnt_q;
    logic        tmo_run;
    logic        link_timeout_q;

    assign tmo_run      = (state_q == StWait) && !turn_q && !interboard_en;
    // A completed guess in the same cycle takes precedence over the timeout
    assign timeout_fire = tmo_run && !guess_done &&
                          (tmo_cnt_q == 20'(TIMEOUT_CYCLES - 1));

    // Silence counter: runs only while waiting on the remote, any message restarts it
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            tmo_cnt_q <= 20'd0;
        end else if (tmo_run) begin
            tmo_cnt_q <= tmo_cnt_q + 20'd1;
        end else begin
            tmo_cnt_q <= 20'd0;
        end
    end

    // Timeout flag: set on a silence-ended game, cleared on restart
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            link_timeout_q <= 1'b0;
        end else if (state_q == StClear) begin
            link_timeout_q <= 1'b0;
        end else if (timeout_fire) begin
            link_timeout_q <= 1'b1;
        end
    end

    assign link_timeout = link_timeout_q;
`else
    assign timeout_fire = 1'b0;
    assign link_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (game_start) state_d = StClear;
            StClear: state_d = StIssue;
            StIssue: state_d = StWait;
            StWait: begin
                if (remote_win) begin
                    state_d = StOver;
                end else if (guess_done) begin
                    state_d = StCheck;
                end else if (timeout_fire) begin
                    state_d = StOver;
                end
            end
            StCheck: state_d = target_hit ? StOver : StIssue;
            StOver:  if (game_start) state_d = StClear;
            default: state_d = StIdle;
        endcase
    end

    // Turn, line count, reported game state and result registers
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            turn_q       <= 1'b0;
            line_count_q <= 4'd0;
            cur_state_q  <= GAME_IDLE;
            winner_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StOver: begin
                    if (game_start) turn_q <= first_player;
                end
                StClear: begin
                    line_count_q <= 4'd0;
                    winner_q     <= 1'b0;
                end
                StIssue: begin
                    cur_state_q <= turn_q ? GAME_P2_GUESS : GAME_WAIT_P1_GUESS;
                end
                StWait: begin
                    if (remote_win || (!guess_done && timeout_fire)) begin
                        winner_q    <= 1'b0;
                        cur_state_q <= GAME_OVER;
                    end
                end
                StCheck: begin
                    line_count_q <= count;
                    if (target_hit) begin
                        winner_q    <= 1'b1;
                        cur_state_q <= GAME_OVER;
                    end else begin
                        turn_q <= ~turn_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode; send requests are Mealy so they line up with guess_done
    always_comb begin
        clear_guess   = 1'b0;
        start_guess   = 1'b0;
        game_over     = 1'b0;
        send_en       = 1'b0;
        send_msg_type = 3'd0;
        case (state_q)
            StClear: clear_guess = 1'b1;
            StIssue: start_guess = 1'b1;
            StWait: begin
                if (!remote_win && guess_done && turn_q) begin
                    send_en       = 1'b1;
                    send_msg_type = MSG_SEL_NUM;
                end
            end
            StCheck: begin
                if (target_hit) begin
                    send_en       = 1'b1;
                    send_msg_type = MSG_STATE_WIN;
                end
            end
            StOver:  game_over = 1'b1;
            default: ;
        endcase
    end

    assign cur_game_state = cur_state_q;
    assign line_count     = line_count_q;
    assign winner         = winner_q;

endmodule

// File: tb/tb_bingo_turn_sched.sv
// Self-checking bench for bingo_turn_sched. Expected send requests go into a
// scoreboard queue when the causing stimulus is driven and are popped by a
// monitor whenever the DUT raises send_en.
module tb_bingo_turn_sched;
    import bingo_turn_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        interboard_rst;
    logic        game_start;
    logic        first_player;
    logic        interboard_en;
    logic [2:0]  interboard_msg_type;
    logic        guess_done;
    logic [24:0] circle;
    logic        clear_guess;
    logic        start_guess;
    logic [3:0]  cur_game_state;
    logic        send_en;
    logic [2:0]  send_msg_type;
    logic [3:0]  line_count;
    logic        game_over;
    logic        winner;
    logic        link_timeout;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [2:0]  sb_q[$];

    bingo_turn_sched #(
        .LINE_TARGET    (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .interboard_rst      (interboard_rst),
        .game_start          (game_start),
        .first_player        (first_player),
        .interboard_en       (interboard_en),
        .interboard_msg_type (interboard_msg_type),
        .guess_done          (guess_done),
        .circle              (circle),
        .clear_guess         (clear_guess),
        .start_guess         (start_guess),
        .cur_game_state      (cur_game_state),
        .send_en             (send_en),
        .send_msg_type       (send_msg_type),
        .line_count          (line_count),
        .game_over           (game_over),
        .winner              (winner),
        .link_timeout        (link_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference line count, built directly from row/col/diagonal cell indices
    function automatic int unsigned model_lines(input logic [24:0] c);
        int unsigned n = 0;
        logic r_ok, c_ok, d_ok, a_ok;
        for (int i = 0; i < 5; i++) begin
            r_ok = 1'b1;
            c_ok = 1'b1;
            for (int j = 0; j < 5; j++) begin
                r_ok &= c[i*5 + j];
                c_ok &= c[j*5 + i];
            end
            n += int'(r_ok) + int'(c_ok);
        end
        d_ok = 1'b1;
        a_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_ok &= c[i*6];
            a_ok &= c[4*(i+1)];
        end
        return n + int'(d_ok) + int'(a_ok);
    endfunction

    // Send monitor: every request must match the next scoreboard entry
    always @(negedge clk) begin
        if (send_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("send_unexpected", {31'd0, send_en}, 32'd0);
            end else begin
                check_eq("send_type", {29'd0, send_msg_type}, {29'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a game and walk through S_CLEAR / S_ISSUE into S_WAIT
    task automatic start_game(input logic fp);
        first_player = fp;
        game_start   = 1'b1;
        step();
        game_start = 1'b0;
        check_eq("clear_pulse", {31'd0, clear_guess}, 32'd1);
        step();
        check_eq("issue_pulse", {31'd0, start_guess}, 32'd1);
        step();
        check_eq("wait_state", {28'd0, cur_game_state},
                 {28'd0, fp ? GAME_P2_GUESS : GAME_WAIT_P1_GUESS});
    endtask

    initial begin
        rst_n               = 1'b0;
        interboard_rst      = 1'b0;
        game_start          = 1'b0;
        first_player        = 1'b0;
        interboard_en       = 1'b0;
        interboard_msg_type = 3'd0;
        guess_done          = 1'b0;
        circle              = 25'd0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check_eq("rst_state", {28'd0, cur_game_state}, {28'd0, GAME_IDLE});
        check_eq("rst_outs", {24'd0, clear_guess, start_guess, send_en, game_over,
                 winner, link_timeout, 2'd0}, 32'd0);
        check_eq("rst_lines", {28'd0, line_count}, 32'd0);

        // Local first: guess -> SEL_NUM same cycle, next issue two cycles later
        start_game(1'b1);
        circle     = 25'd0;
        guess_done = 1'b1;
        sb_q.push_back(MSG_SEL_NUM);
        step();
        guess_done = 1'b0;
        check_eq("check_no_issue", {31'd0, start_guess}, 32'd0);
        step();
        check_eq("turn_latency", {31'd0, start_guess}, 32'd1);
        check_eq("lines_zero", {28'd0, line_count}, model_lines(25'd0));
        step();
        check_eq("remote_turn", {28'd0, cur_game_state}, {28'd0, GAME_WAIT_P1_GUESS});

        // Remote win collides with guess_done: remote win takes priority, no send
        interboard_en       = 1'b1;
        interboard_msg_type = MSG_STATE_WIN;
        guess_done          = 1'b1;
        step();
        interboard_en       = 1'b0;
        interboard_msg_type = 3'd0;
        guess_done          = 1'b0;
        check_eq("rwin_over", {31'd0, game_over}, 32'd1);
        check_eq("rwin_winner", {31'd0, winner}, 32'd0);
        check_eq("rwin_state", {28'd0, cur_game_state}, {28'd0, GAME_OVER});
        check_eq("rwin_no_tmo", {31'd0, link_timeout}, 32'd0);

        // Local win: row 0 + col 0 + diagonal = 3 lines
        start_game(1'b1);
        circle     = 25'h000001F | 25'h0108421 | 25'h1041041;
        guess_done = 1'b1;
        sb_q.push_back(MSG_SEL_NUM);
        sb_q.push_back(MSG_STATE_WIN);
        step();
        guess_done = 1'b0;
        step();
        check_eq("win_lines", {28'd0, line_count}, model_lines(circle));
        check_eq("win_over", {31'd0, game_over}, 32'd1);
        check_eq("win_winner", {31'd0, winner}, 32'd1);
        step();
        check_eq("win_hold", {31'd0, game_over}, 32'd1);

        // 4-of-5 row counts nothing, full card counts 12
        start_game(1'b0);
        circle     = 25'h000000F;
        guess_done = 1'b1;
        step();
        guess_done = 1'b0;
        step();
        check_eq("partial_issue", {31'd0, start_guess}, 32'd1);
        check_eq("partial_lines", {28'd0, line_count}, model_lines(circle));
        step();
        check_eq("local_turn", {28'd0, cur_game_state}, {28'd0, GAME_P2_GUESS});
        circle     = 25'h1FFFFFF;
        guess_done = 1'b1;
        sb_q.push_back(MSG_SEL_NUM);
        sb_q.push_back(MSG_STATE_WIN);
        step();
        guess_done = 1'b0;
        step();
        check_eq("full_lines", {28'd0, line_count}, model_lines(circle));
        check_eq("full_winner", {31'd0, winner}, 32'd1);

        // Reset mid-wait, game_start ignored while waiting, peer abort
        start_game(1'b1);
        game_start = 1'b1;
        step();
        game_start = 1'b0;
        check_eq("start_ignored", {31'd0, clear_guess}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("mid_rst_state", {28'd0, cur_game_state}, {28'd0, GAME_IDLE});
        check_eq("mid_rst_lines", {28'd0, line_count}, 32'd0);
        check_eq("mid_rst_outs", {26'd0, clear_guess, start_guess, send_en, game_over,
                 winner, link_timeout}, 32'd0);
        start_game(1'b0);
        interboard_rst = 1'b1;
        step();
        interboard_rst = 1'b0;
        check_eq("ib_rst_state", {28'd0, cur_game_state}, {28'd0, GAME_IDLE});
        check_eq("ib_rst_outs", {26'd0, clear_guess, start_guess, send_en, game_over,
                 winner, link_timeout}, 32'd0);
        start_game(1'b0);

`ifdef BINGO_LINK_TIMEOUT_EN
        // Remote silent; a message at wait cycle 10 restarts the 16-cycle count
        for (int k = 0; k < 10; k++) step();
        interboard_en       = 1'b1;
        interboard_msg_type = MSG_SEL_NUM;
        step();
        interboard_en       = 1'b0;
        interboard_msg_type = 3'd0;
        for (int k = 0; k < 15; k++) step();
        check_eq("tmo_not_yet", {31'd0, game_over}, 32'd0);
        step();
        check_eq("tmo_over", {31'd0, game_over}, 32'd1);
        check_eq("tmo_flag", {31'd0, link_timeout}, 32'd1);
        check_eq("tmo_winner", {31'd0, winner}, 32'd0);
`else
        // Without the timeout option the remote turn waits indefinitely
        for (int k = 0; k < 40; k++) step();
        check_eq("no_tmo_wait", {31'd0, game_over}, 32'd0);
        check_eq("no_tmo_flag", {31'd0, link_timeout}, 32'd0);
`endif

        step();
        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
